// File: rtl/cmos_pkg.sv
// Shared definitions for the OV5640 sync-stream statistics block.
//   state_e    : qualifier FSM encoding (S_IDLE, S_SYNC, S_SKIP, S_RUN)
//   CNT_W_DEF  : default width of the line and byte counters
package cmos_pkg;

    localparam int unsigned CNT_W_DEF = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_SKIP = 2'd2,
        S_RUN  = 2'd3
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Single-register edge detector for a sync signal.
//   clk_i    : clock
//   rst_ni   : asynchronous reset, active low
//   sig_i    : raw level input
//   sig_q_o  : input delayed by one clock
//   rise_o   : sig_i high while the registered copy is low
//   fall_o   : sig_i low while the registered copy is high
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic sig_q_o,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign sig_q_o = sig_q;
    assign rise_o  = sig_i & ~sig_q;
    assign fall_o  = ~sig_i & sig_q;

endmodule

// File: rtl/cmos_frame_stat.sv
// OV5640 sync-stream measurement and qualification.
// Counts bytes per line, lines per frame and frames per CLK_FREQ-cycle window, and raises
// frameDelay once Init_Done is high and SKIP_FRAMES whole frames have gone by.
//   iCLK           : pixel clock, sole clock
//   iRST_N         : asynchronous reset, active low
//   Init_Done      : sensor configuration complete (level)
//   iVSYNC         : 1 = frame active
//   iHREF          : 1 = line active
//   frameDelay     : 1 = stream qualified
//   in_cmos_vs_cnt : lines in the last completed frame
//   in_cmos_hs_cnt : bytes in the last completed line
//   oFPS           : frames completed in the last window
//   oOVF           : sticky, a line/byte counter saturated
module cmos_frame_stat
    import cmos_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 24_000_000,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             Init_Done,
    input  logic             iVSYNC,
    input  logic             iHREF,
    output logic             frameDelay,
    output logic [CNT_W-1:0] in_cmos_vs_cnt,
    output logic [CNT_W-1:0] in_cmos_hs_cnt,
    output logic [7:0]       oFPS,
    output logic             oOVF
);

    localparam int unsigned SEC_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic vs_q, vs_rise, vs_fall;
    logic hs_q, hs_rise, hs_fall;
    logic unused_hs;

    sync_edge_det u_vs_det (
        .clk_i   (iCLK),
        .rst_ni  (iRST_N),
        .sig_i   (iVSYNC),
        .sig_q_o (vs_q),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    sync_edge_det u_hs_det (
        .clk_i   (iCLK),
        .rst_ni  (iRST_N),
        .sig_i   (iHREF),
        .sig_q_o (hs_q),
        .rise_o  (hs_rise),
        .fall_o  (hs_fall)
    );

    assign unused_hs = ^{hs_q, hs_rise};

    // Measurement datapath
    logic [CNT_W-1:0] byte_q, byte_d, line_q, line_d, line_plus;
    logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d, vs_cnt_q, vs_cnt_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [7:0]       frm_q, frm_d, frm_plus, fps_q, fps_d;
    logic             ovf_q, ovf_d, sec_wrap;

    always_comb begin
        byte_d   = byte_q;
        line_d   = line_q;
        hs_cnt_d = hs_cnt_q;
        vs_cnt_d = vs_cnt_q;
        frm_d    = frm_q;
        fps_d    = fps_q;

        if (hs_fall) begin
            hs_cnt_d = byte_q;
            byte_d   = '0;
        end else if (iVSYNC && iHREF && (byte_q != CntMax)) begin
            byte_d = byte_q + 1'b1;
        end

        // Includes a line ending in the same cycle so vs_fall sees the complete count.
        line_plus = (hs_fall && vs_q && (line_q != CntMax)) ? line_q + 1'b1 : line_q;
        if (vs_fall) begin
            vs_cnt_d = line_plus;
            line_d   = '0;
        end else if (vs_rise) begin
            line_d = '0;
        end else begin
            line_d = line_plus;
        end

        ovf_d = ovf_q | (byte_d == CntMax) | (line_plus == CntMax);

        sec_wrap = (32'(sec_q) == CLK_FREQ - 1);
        sec_d    = sec_wrap ? '0 : sec_q + 1'b1;

        // A frame ending on the wrap cycle belongs to the window that is closing.
        frm_plus = (vs_fall && (frm_q != 8'hFF)) ? frm_q + 8'd1 : frm_q;
        if (sec_wrap) begin
            fps_d = frm_plus;
            frm_d = 8'd0;
        end else begin
            frm_d = frm_plus;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            byte_q   <= '0;
            line_q   <= '0;
            hs_cnt_q <= '0;
            vs_cnt_q <= '0;
            sec_q    <= '0;
            frm_q    <= 8'd0;
            fps_q    <= 8'd0;
            ovf_q    <= 1'b0;
        end else begin
            byte_q   <= byte_d;
            line_q   <= line_d;
            hs_cnt_q <= hs_cnt_d;
            vs_cnt_q <= vs_cnt_d;
            sec_q    <= sec_d;
            frm_q    <= frm_d;
            fps_q    <= fps_d;
            ovf_q    <= ovf_d;
        end
    end

    // Qualifier FSM
    state_e            state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              fd_q, fd_d;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        case (state_q)
            S_IDLE: begin
                if (Init_Done) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                // Start skipping only at a frame start so a partial frame never counts.
                if (vs_rise) begin
                    skip_d  = '0;
                    state_d = (SKIP_FRAMES == 0) ? S_RUN : S_SKIP;
                end
            end
            S_SKIP: begin
                if (vs_fall) begin
                    if (32'(skip_q) == SKIP_FRAMES - 1) begin
                        state_d = S_RUN;
                    end else begin
                        skip_d = skip_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
            end
            default: state_d = S_IDLE;
        endcase
        if (!Init_Done) begin
            state_d = S_IDLE;
        end
        // High one cycle after entering S_RUN; drops with the same edge that leaves it.
        fd_d = (state_q == S_RUN) && (state_d == S_RUN);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            fd_q    <= fd_d;
        end
    end

    assign frameDelay     = fd_q;
    assign in_cmos_vs_cnt = vs_cnt_q;
    assign in_cmos_hs_cnt = hs_cnt_q;
    assign oFPS           = fps_q;
    assign oOVF           = ovf_q;

endmodule

// File: tb/tb_cmos_frame_stat.sv
// Directed bench for cmos_frame_stat. Stimulus pushes timed expectations into a scoreboard;
// a negedge monitor compares every entry whose due cycle has arrived.
module tb_cmos_frame_stat;

    localparam int ID_AHS   = 0;
    localparam int ID_AVS   = 1;
    localparam int ID_AFPS  = 2;
    localparam int ID_AFD   = 3;
    localparam int ID_AOVF  = 4;
    localparam int ID_ASTAT = 5;
    localparam int ID_BHS   = 6;
    localparam int ID_BVS   = 7;
    localparam int ID_BOVF  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        vsync;
    logic        href;
    logic        a_fd, a_ovf, b_fd, b_ovf;
    logic [11:0] a_vs, a_hs;
    logic [3:0]  b_vs, b_hs;
    logic [7:0]  a_fps, b_fps;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        int exp;
        int due;
    } exp_t;
    exp_t sb[$];

    cmos_frame_stat #(
        .CLK_FREQ    (1000),
        .SKIP_FRAMES (2),
        .CNT_W       (12)
    ) dut_a (
        .iCLK           (clk),
        .iRST_N         (rst_n),
        .Init_Done      (init_done),
        .iVSYNC         (vsync),
        .iHREF          (href),
        .frameDelay     (a_fd),
        .in_cmos_vs_cnt (a_vs),
        .in_cmos_hs_cnt (a_hs),
        .oFPS           (a_fps),
        .oOVF           (a_ovf)
    );

    cmos_frame_stat #(
        .CLK_FREQ    (1000),
        .SKIP_FRAMES (2),
        .CNT_W       (4)
    ) dut_b (
        .iCLK           (clk),
        .iRST_N         (rst_n),
        .Init_Done      (init_done),
        .iVSYNC         (vsync),
        .iHREF          (href),
        .frameDelay     (b_fd),
        .in_cmos_vs_cnt (b_vs),
        .in_cmos_hs_cnt (b_hs),
        .oFPS           (b_fps),
        .oOVF           (b_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string name_of(input int id);
        case (id)
            ID_AHS:   return "a_hs_cnt";
            ID_AVS:   return "a_vs_cnt";
            ID_AFPS:  return "a_fps";
            ID_AFD:   return "a_frameDelay";
            ID_AOVF:  return "a_ovf";
            ID_ASTAT: return "a_state";
            ID_BHS:   return "b_hs_cnt";
            ID_BVS:   return "b_vs_cnt";
            default:  return "b_ovf";
        endcase
    endfunction

    function automatic int get_val(input int id);
        case (id)
            ID_AHS:   return int'(a_hs);
            ID_AVS:   return int'(a_vs);
            ID_AFPS:  return int'(a_fps);
            ID_AFD:   return int'(a_fd);
            ID_AOVF:  return int'(a_ovf);
            ID_ASTAT: return int'(dut_a.state_q);
            ID_BHS:   return int'(b_hs);
            ID_BVS:   return int'(b_vs);
            default:  return int'(b_ovf);
        endcase
    endfunction

    task automatic check(input int id, input int exp);
        int act;
        act = get_val(id);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name_of(id), act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                check(sb[i].id, sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input int id, input int exp, input int delay);
        exp_t e;
        e.id  = id;
        e.exp = exp;
        e.due = cyc + delay;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic send_line(input int n);
        href = 1'b1;
        repeat (n) tick();
        href = 1'b0;
        expect_at(ID_AHS, n, 2);
        expect_at(ID_BHS, sat15(n), 2);
        repeat (3) tick();
    endtask

    // fd1/fd2: expected frameDelay one and two cycles after the frame end (-1 = no check).
    task automatic send_frame(input int lines, input int bytes, input int fd1, input int fd2);
        vsync = 1'b1;
        repeat (2) tick();
        for (int l = 0; l < lines; l++) send_line(bytes);
        vsync = 1'b0;
        expect_at(ID_AVS, lines, 2);
        expect_at(ID_BVS, sat15(lines), 2);
        if (fd1 >= 0) expect_at(ID_AFD, fd1, 1);
        if (fd2 >= 0) expect_at(ID_AFD, fd2, 2);
        repeat (4) tick();
    endtask

    task automatic expect_a_zero();
        expect_at(ID_AHS, 0, 0);
        expect_at(ID_AVS, 0, 0);
        expect_at(ID_AFPS, 0, 0);
        expect_at(ID_AFD, 0, 0);
        expect_at(ID_AOVF, 0, 0);
        expect_at(ID_ASTAT, 0, 0);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        init_done = 1'b0;
        vsync     = 1'b0;
        href      = 1'b0;

        // Reset state
        repeat (3) tick();
        expect_a_zero();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Geometry, and Init_Done raised mid-frame: this frame must not be counted as skipped
        vsync = 1'b1;
        repeat (2) tick();
        send_line(16);
        send_line(16);
        init_done = 1'b1;
        expect_at(ID_ASTAT, 1, 1);
        send_line(16);
        send_line(16);
        vsync = 1'b0;
        expect_at(ID_AVS, 4, 2);
        expect_at(ID_BVS, 4, 2);
        expect_at(ID_AFD, 0, 2);
        repeat (4) tick();
        send_frame(4, 16, 0, 0);
        send_frame(4, 16, 0, 1);
        send_frame(3, 10, 1, 1);

        // Drop Init_Done in S_RUN, then re-qualify
        init_done = 1'b0;
        expect_at(ID_AFD, 0, 1);
        expect_at(ID_ASTAT, 0, 1);
        repeat (3) tick();
        vsync = 1'b1;
        repeat (2) tick();
        send_line(16);
        init_done = 1'b1;
        expect_at(ID_ASTAT, 1, 1);
        send_line(16);
        vsync = 1'b0;
        expect_at(ID_AVS, 2, 2);
        expect_at(ID_AFD, 0, 2);
        repeat (4) tick();
        send_frame(4, 16, 0, 0);
        expect_at(ID_ASTAT, 2, 0);
        send_frame(2, 8, 0, 1);

        // Asynchronous reset mid-line
        vsync = 1'b1;
        repeat (2) tick();
        href = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        expect_a_zero();
        expect_at(ID_BOVF, 0, 0);
        tick();
        href  = 1'b0;
        vsync = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Overflow on the 4-bit instance
        vsync = 1'b1;
        repeat (2) tick();
        send_line(12);
        expect_at(ID_BOVF, 0, 0);
        send_line(20);
        expect_at(ID_BOVF, 1, 0);
        expect_at(ID_AOVF, 0, 0);
        send_line(5);
        expect_at(ID_BOVF, 1, 0);
        vsync = 1'b0;
        expect_at(ID_AVS, 3, 2);
        expect_at(ID_BVS, 3, 2);
        repeat (4) tick();
        rst_n = 1'b0;
        expect_at(ID_BOVF, 0, 0);
        tick();
        rst_n = 1'b1;

        // FPS: one frame per 100 cycles, each frame ending on an edge that is a multiple of 100
        base = cyc;
        expect_at(ID_AFPS, 0, 500);
        expect_at(ID_AFPS, 10, 1000);
        expect_at(ID_AFPS, 10, 1001);
        expect_at(ID_AFPS, 10, 2001);
        expect_at(ID_AFPS, 10, 3001);
        for (int k = 0; k < 3002; k++) begin
            int kk;
            tick();
            kk = cyc - base;
            if (kk % 100 == 30) vsync = 1'b1;
            if (kk % 100 == 99) vsync = 1'b0;
        end

        for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: got unchecked, expected checked by cycle %0d",
                     name_of(sb[0].id), sb[0].due);
            void'(sb.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
